// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix
  } div_state_e;

  localparam int unsigned DIV_WIDTH = 32;

  // Iteration counter must hold 0..width, hence width+1 codes.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  localparam logic [DIV_WIDTH-1:0] DIV_MIN_INT = {1'b1, {(DIV_WIDTH-1){1'b0}}};
  localparam logic [DIV_WIDTH-1:0] DIV_MAX_INT = {1'b0, {(DIV_WIDTH-1){1'b1}}};
  localparam int unsigned          DIV_CNT_W   = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtractor for one restoring-division step: a - b with borrow-out.
module div_trial_sub #(
  parameter int unsigned Width = 33
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] diff_o,
  output logic             borrow_o
);

  always_comb begin
    {borrow_o, diff_o} = {1'b0, a_i} - {1'b0, b_i};
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed restoring divider, truncating toward zero, with
// divide-by-zero and MIN_INT / -1 overflow flags.
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             divByZero,
  output logic             posOverflow
);

  localparam int unsigned      CntW     = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] MinInt   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] AllOnes  = {WIDTH{1'b1}};
  localparam logic [CntW-1:0]  LastIter = CntW'(WIDTH - 1);

  div_state_e       state_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] babs_q;
  logic [CntW-1:0]  cnt_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             dbz_q;
  logic             ovf_q;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             is_zero;
  logic             is_ovf;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial_diff;
  logic             trial_borrow;
  logic             unused_diff_msb;

  always_comb begin
    a_abs     = A[WIDTH-1] ? -A : A;
    b_abs     = B[WIDTH-1] ? -B : B;
    is_zero   = (B == '0);
    is_ovf    = (A == MinInt) && (B == AllOnes);
    rem_shift = {rem_q, quot_q[WIDTH-1]};
  end

  div_trial_sub #(
    .Width(WIDTH + 1)
  ) u_trial_sub (
    .a_i     (rem_shift),
    .b_i     ({1'b0, babs_q}),
    .diff_o  (trial_diff),
    .borrow_o(trial_borrow)
  );

  // A kept difference is below |B| <= 2^(WIDTH-1), so its top bit is always zero.
  assign unused_diff_msb = trial_diff[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      quot_q      <= '0;
      babs_q      <= '0;
      cnt_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      ready       <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      Q           <= '0;
      R           <= '0;
      divByZero   <= 1'b0;
      posOverflow <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            busy        <= 1'b1;
            ready       <= 1'b0;
            cnt_q       <= '0;
            divByZero   <= 1'b0;
            posOverflow <= 1'b0;
            dbz_q       <= is_zero;
            ovf_q       <= is_ovf;
            if (is_zero) begin
              // Results are preloaded so FIX passes them through unchanged.
              quot_q  <= AllOnes;
              rem_q   <= A;
              qneg_q  <= 1'b0;
              rneg_q  <= 1'b0;
              state_q <= StFix;
            end else if (is_ovf) begin
              quot_q  <= MinInt;
              rem_q   <= '0;
              qneg_q  <= 1'b0;
              rneg_q  <= 1'b0;
              state_q <= StFix;
            end else begin
              quot_q  <= a_abs;
              rem_q   <= '0;
              babs_q  <= b_abs;
              qneg_q  <= A[WIDTH-1] ^ B[WIDTH-1];
              rneg_q  <= A[WIDTH-1];
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          // quot_q shifts out dividend bits at the top and quotient bits in at the bottom.
          rem_q  <= trial_borrow ? rem_shift[WIDTH-1:0] : trial_diff[WIDTH-1:0];
          quot_q <= {quot_q[WIDTH-2:0], ~trial_borrow};
          cnt_q  <= cnt_q + CntW'(1);
          if (cnt_q == LastIter) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          Q           <= qneg_q ? -quot_q : quot_q;
          R           <= rneg_q ? -rem_q : rem_q;
          divByZero   <= dbz_q;
          posOverflow <= ovf_q;
          done        <= 1'b1;
          busy        <= 1'b0;
          ready       <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
